// File: rtl/scan_datamux.sv
// Registered N-channel data selector: direct mode streams din[sel]; scan mode
// walks the enabled channels of a latched mask in ascending order, then pulses done.
module scan_datamux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      start,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, SCAN, LAST} state_t;

    state_t              state;
    logic [CHANNELS-1:0] mask;
    logic [SEL_W-1:0]    ptr;
    logic                load_ok;
    logic                xfer;
    logic [SEL_W:0]      first_hit;
    logic [SEL_W:0]      next_first;
    logic [SEL_W:0]      next_ptr;

    // Out-of-range indices select nothing and return zero.
    function automatic logic [WIDTH-1:0] chan(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx == SEL_W'(i)) res = bus[i*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above 'from' (or anywhere if any_pos).
    function automatic logic [SEL_W:0] lowest_above(input logic [CHANNELS-1:0] m,
                                                    input logic [SEL_W-1:0] from,
                                                    input logic any_pos);
        logic [SEL_W:0] res;
        logic           found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found && m[i] && (any_pos || SEL_W'(i) > from)) begin
                found = 1'b1;
                res   = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    assign first_hit  = lowest_above(en_mask, '0, 1'b1);
    assign next_first = lowest_above(en_mask, first_hit[SEL_W-1:0], 1'b0);
    assign next_ptr   = lowest_above(mask, ptr, 1'b0);

    always_comb begin
        load_ok = !out_valid || out_ready;
        xfer    = out_valid && out_ready;
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            ptr       <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!mode) begin
                        if (load_ok) begin
                            out_data  <= chan(din, sel);
                            out_idx   <= sel;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        if (xfer) out_valid <= 1'b0;
                        if (start && load_ok) begin
                            if (!first_hit[SEL_W]) begin
                                done <= 1'b1;
                            end else begin
                                mask      <= en_mask;
                                out_data  <= chan(din, first_hit[SEL_W-1:0]);
                                out_idx   <= first_hit[SEL_W-1:0];
                                out_valid <= 1'b1;
                                ptr       <= next_first[SEL_W-1:0];
                                state     <= next_first[SEL_W] ? SCAN : LAST;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (load_ok) begin
                        out_data  <= chan(din, ptr);
                        out_idx   <= ptr;
                        out_valid <= 1'b1;
                        if (next_ptr[SEL_W]) ptr <= next_ptr[SEL_W-1:0];
                        else state <= LAST;
                    end
                end
                LAST: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_datamux.sv
// Randomized self-checking bench for scan_datamux: default instance against a
// transaction-level model, plus a CHANNELS=6/WIDTH=12 instance with directed checks.
module tb_scan_datamux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  en_mask;
    logic        start;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [71:0] d6_din;
    logic        d6_mode;
    logic [2:0]  d6_sel;
    logic [5:0]  d6_mask;
    logic        d6_start;
    logic        d6_ready;
    logic [11:0] d6_data;
    logic [2:0]  d6_idx;
    logic        d6_valid;
    logic        d6_busy;
    logic        d6_done;

    int checks = 0;
    int errors = 0;

    // direct-mode model state
    logic       mv;
    logic [3:0] md;
    logic [2:0] mi;

    always #5 clk = ~clk;

    scan_datamux dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .sel(sel), .en_mask(en_mask),
        .start(start), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    scan_datamux #(.WIDTH(12), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .din(d6_din), .mode(d6_mode), .sel(d6_sel), .en_mask(d6_mask),
        .start(d6_start), .out_data(d6_data), .out_idx(d6_idx), .out_valid(d6_valid),
        .out_ready(d6_ready), .busy(d6_busy), .done(d6_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_a(input logic [31:0] bus, input int i);
        logic [31:0] s;
        s = bus >> (i * 4);
        return (i < 8) ? s[3:0] : 4'h0;
    endfunction

    function automatic logic [11:0] ref_6(input logic [71:0] bus, input int i);
        logic [71:0] s;
        s = bus >> (i * 12);
        return (i < 6) ? s[11:0] : 12'h0;
    endfunction

    task automatic run_direct(input int n);
        logic lok;
        mode = 1'b0;
        for (int k = 0; k < n; k++) begin
            din       = $urandom;
            sel       = 3'($urandom);
            start     = 1'($urandom);
            en_mask   = 8'($urandom);
            out_ready = 1'($urandom);
            lok = !mv || out_ready;
            if (lok) begin
                mv = 1'b1;
                md = ref_a(din, int'(sel));
                mi = sel;
            end
            tick();
            check("dir_valid", out_valid, mv);
            if (mv) begin
                check("dir_data", out_data, md);
                check("dir_idx", out_idx, mi);
            end
            check("dir_busy", busy, 0);
            check("dir_done", done, 0);
        end
    endtask

    task automatic run_scan(input logic [7:0] m, input int ready_pct, input bit noise);
        int         q[$];
        int         k0;
        int         loops;
        bit         got_done;
        logic [31:0] din_s;
        logic       v, r;
        logic [3:0] pd;
        logic [2:0] pi;

        mode = 1'b1; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
        k0 = q.size();
        din_s = din;
        en_mask = m; start = 1'b1;
        tick();
        start = 1'b0;
        if (k0 == 0) begin
            check("empty_done", done, 1);
            check("empty_valid", out_valid, 0);
            check("empty_busy", busy, 0);
            tick();
            check("empty_done_once", done, 0);
            check("empty_busy2", busy, 0);
            return;
        end
        check("scan_busy_start", busy, 1);
        got_done = 1'b0;
        loops = 0;
        while (!got_done && loops < 100) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (noise) begin
                start   = 1'($urandom);
                mode    = 1'($urandom);
                sel     = 3'($urandom);
                en_mask = 8'($urandom);
            end
            v = out_valid; r = out_ready; pd = out_data; pi = out_idx;
            check("scan_valid", v, 1);
            tick();
            loops++;
            if (v && r) begin
                check("scan_idx", pi, q[0]);
                check("scan_data", pd, ref_a(din_s, q[0]));
                void'(q.pop_front());
            end else if (v) begin
                check("hold_data", out_data, pd);
                check("hold_idx", out_idx, pi);
            end
            if (q.size() == 0) begin
                check("scan_done", done, 1);
                check("scan_end_busy", busy, 0);
                check("scan_end_valid", out_valid, 0);
                got_done = 1'b1;
            end else begin
                check("no_early_done", done, 0);
                check("scan_busy", busy, 1);
            end
        end
        if (!got_done) check("scan_timeout", 0, 1);
        if (ready_pct >= 100) check("scan_cycles", loops, k0);
        mode = 1'b1; start = 1'b0;
        tick();
        check("done_once", done, 0);
    endtask

    initial begin
        rst = 1'b1;
        din = '0; mode = 1'b0; sel = '0; en_mask = '0; start = 1'b0; out_ready = 1'b1;
        d6_din = '0; d6_mode = 1'b1; d6_sel = '0; d6_mask = '0; d6_start = 1'b0; d6_ready = 1'b1;
        tick(); tick();
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst6_valid", d6_valid, 0);
        rst = 1'b0;

        din = 32'h5000_A000;
        sel = 3'd3;
        tick();
        check("d_a_data", out_data, 4'hA);
        check("d_a_idx", out_idx, 3);
        check("d_a_valid", out_valid, 1);
        sel = 3'd7;
        tick();
        check("d_b_data", out_data, 4'h5);
        check("d_b_idx", out_idx, 7);
        check("d_b_valid", out_valid, 1);
        mv = 1'b1; md = 4'h5; mi = 3'd7;
        run_direct(150);

        din = 32'h8765_4321;
        run_scan(8'b1010_0101, 100, 1'b0);
        run_scan(8'h00, 100, 1'b0);
        run_scan(8'b1010_0101, 40, 1'b1);
        run_scan(8'h80, 100, 1'b0);
        for (int n = 0; n < 24; n++) begin
            din = $urandom;
            run_scan(8'($urandom), (n % 3 == 0) ? 100 : 50, n[0]);
        end

        mv = 1'b0;
        run_direct(60);

        // abort a scan with reset
        mode = 1'b1; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        en_mask = 8'hFF; start = 1'b1; din = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("abort_data", out_data, 0);
        check("abort_idx", out_idx, 0);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_idle_valid", out_valid, 0);
        end

        d6_mode = 1'b0; d6_sel = 3'd6;
        d6_din = {8'($urandom), 32'($urandom), 32'($urandom)};
        tick();
        check("p6_sel6_data", d6_data, 0);
        check("p6_sel6_idx", d6_idx, 6);
        check("p6_sel6_valid", d6_valid, 1);
        d6_sel = 3'd2;
        tick();
        check("p6_sel2_data", d6_data, ref_6(d6_din, 2));
        d6_mode = 1'b1;
        tick();
        check("p6_drain", d6_valid, 0);
        d6_mask = 6'b100001; d6_start = 1'b1;
        tick();
        d6_start = 1'b0;
        check("p6_b0_idx", d6_idx, 0);
        check("p6_b0_data", d6_data, ref_6(d6_din, 0));
        check("p6_b0_busy", d6_busy, 1);
        tick();
        check("p6_b1_idx", d6_idx, 5);
        check("p6_b1_data", d6_data, ref_6(d6_din, 5));
        check("p6_b1_valid", d6_valid, 1);
        tick();
        check("p6_done", d6_done, 1);
        check("p6_end_valid", d6_valid, 0);
        check("p6_end_busy", d6_busy, 0);
        tick();
        check("p6_done_once", d6_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
